pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush scheduler for the 5-stage MIPS pipeline; sits beside the ID stage.

---
 rtl/pipe_hazard_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: merges load-use, MDU occupancy,
// data-memory wait and EX branch redirect into stage enables, bubble flushes and counters.
module pipe_hazard_ctrl #(
    parameter int LOAD_STALL_CYC = 1,
    parameter int MDU_LAT        = 4,
    parameter int MEM_TIMEOUT    = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_mdu_op,
    input  logic [2:0]       ex_mem_out_ctr,
    input  logic [4:0]       ex_rt,
    input  logic             ex_mdu_start,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mdu_busy,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int LU_W   = 2;
    localparam int MDU_W  = 4;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [LU_W-1:0]   LU_RELOAD = LU_W'(LOAD_STALL_CYC - 1);
    localparam logic [LU_W-1:0]   LU_ZERO   = {LU_W{1'b0}};
    localparam logic [LU_W-1:0]   LU_ONE    = LU_W'(1);
    localparam logic [MDU_W-1:0]  MDU_LOAD  = MDU_W'(MDU_LAT);
    localparam logic [MDU_W-1:0]  MDU_ZERO  = {MDU_W{1'b0}};
    localparam logic [MDU_W-1:0]  MDU_ONE   = MDU_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MDU_WAIT = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [LU_W-1:0]   lu_cnt_r;
    logic [LU_W-1:0]   lu_cnt_nxt_s;
    logic [MDU_W-1:0]  mdu_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              mem_timeout_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic              freeze_s;
    logic              lu_hazard_s;
    logic              mdu_busy_s;
    logic              stall_s;

    assign freeze_s    = dmem_req & ~dmem_ready;
    assign lu_hazard_s = (ex_mem_out_ctr != 3'd0) && (ex_rt != 5'd0) &&
                         ((id_uses_rs && (ex_rt == id_rs)) || (id_uses_rt && (ex_rt == id_rt)));
    assign mdu_busy_s   = (mdu_cnt_r != MDU_ZERO);
    assign mdu_busy     = mdu_busy_s;
    assign mem_timeout  = mem_timeout_r;
    assign stall_cycles = stall_cnt_r;

    // Priority resolution of freeze > branch > load-use > MDU into enables, flushes and next state
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        state_nxt_s  = state_r;
        lu_cnt_nxt_s = lu_cnt_r;
        stall_s      = 1'b0;
        if (!rst_n) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            state_nxt_s  = RUN;
            lu_cnt_nxt_s = LU_ZERO;
        end else if (freeze_s) begin
            // Whole pipe holds; pending hazard decisions are retried once memory answers
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            state_nxt_s  = RUN;
            lu_cnt_nxt_s = LU_ZERO;
        end else begin
            case (state_r)
                RUN: begin
                    if (lu_hazard_s) begin
                        stall_s = 1'b1;
                        if (LOAD_STALL_CYC > 1) begin
                            lu_cnt_nxt_s = LU_RELOAD;
                            state_nxt_s  = LU_STALL;
                        end else begin
                            state_nxt_s = RUN;
                        end
                    end else if (id_mdu_op && mdu_busy_s) begin
                        stall_s     = 1'b1;
                        state_nxt_s = MDU_WAIT;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                LU_STALL: begin
                    stall_s      = 1'b1;
                    lu_cnt_nxt_s = lu_cnt_r - LU_ONE;
                    if (lu_cnt_r == LU_ONE) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = LU_STALL;
                    end
                end
                MDU_WAIT: begin
                    if (mdu_busy_s) begin
                        stall_s = 1'b1;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                default: begin
                    state_nxt_s  = RUN;
                    lu_cnt_nxt_s = LU_ZERO;
                end
            endcase
            if (stall_s) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else begin
                pc_en = 1'b1;
            end
        end
    end

    // Hazard state and remaining load-use bubble count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= RUN;
            lu_cnt_r <= LU_ZERO;
        end else begin
            state_r  <= state_nxt_s;
            lu_cnt_r <= lu_cnt_nxt_s;
        end
    end

    // HI/LO occupancy: a frozen EX stage has not really issued its mult/div yet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_cnt_r <= MDU_ZERO;
        end else if (ex_mdu_start && !freeze_s) begin
            mdu_cnt_r <= MDU_LOAD;
        end else if (mdu_busy_s) begin
            mdu_cnt_r <= mdu_cnt_r - MDU_ONE;
        end
    end

    // Consecutive memory-wait watchdog with sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r    <= WAIT_ZERO;
            mem_timeout_r <= 1'b0;
        end else if (freeze_s) begin
            if (wait_cnt_r >= WAIT_LAST) begin
                mem_timeout_r <= 1'b1;
            end
            if (wait_cnt_r != WAIT_MAX) begin
                wait_cnt_r <= wait_cnt_r + WAIT_ONE;
            end
        end else begin
            wait_cnt_r <= WAIT_ZERO;
        end
    end

    // Saturating count of cycles in which the PC did not advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= CNT_ZERO;
        end else if (!pc_en && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: three instances (1, 2, 3 load bubbles) share
// stimulus; directed scenarios plus a randomized run against a bubble-count reference model.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rs, id_uses_rt, id_mdu_op;
    logic [2:0] ex_mem_out_ctr;
    logic       ex_mdu_start, ex_branch_taken, dmem_req, dmem_ready;

    logic        pc_en [3];
    logic        ifid_en [3];
    logic        idex_en [3];
    logic        exmem_en [3];
    logic        memwb_en [3];
    logic        ifid_flush [3];
    logic        idex_flush [3];
    logic        mdu_busy [3];
    logic        mem_timeout [3];
    logic [15:0] stall_cycles [3];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pipe_hazard_ctrl #(
            .LOAD_STALL_CYC(g + 1), .MDU_LAT(4), .MEM_TIMEOUT(64), .CNT_W(16)
        ) dut (
            .clk(clk), .rst_n(rst_n),
            .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
            .id_mdu_op(id_mdu_op), .ex_mem_out_ctr(ex_mem_out_ctr), .ex_rt(ex_rt),
            .ex_mdu_start(ex_mdu_start), .ex_branch_taken(ex_branch_taken),
            .dmem_req(dmem_req), .dmem_ready(dmem_ready),
            .pc_en(pc_en[g]), .ifid_en(ifid_en[g]), .idex_en(idex_en[g]),
            .exmem_en(exmem_en[g]), .memwb_en(memwb_en[g]),
            .ifid_flush(ifid_flush[g]), .idex_flush(idex_flush[g]),
            .mdu_busy(mdu_busy[g]), .mem_timeout(mem_timeout[g]),
            .stall_cycles(stall_cycles[g])
        );
    end

    // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    function automatic logic [6:0] outs(input int k);
        return {pc_en[k], ifid_en[k], idex_en[k], exmem_en[k], memwb_en[k],
                ifid_flush[k], idex_flush[k]};
    endfunction

    task automatic set_idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_mdu_op = 1'b0;
        ex_mem_out_ctr = 3'd0; ex_mdu_start = 1'b0; ex_branch_taken = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic set_lw_hazard();
        ex_mem_out_ctr = 3'b001; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        id_rt = 5'd7; id_uses_rt = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (outs(k) !== 7'b0000011) $display("FAIL reset_outs[%0d]: got %b expected %b", k, outs(k), 7'b0000011);
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if ({mdu_busy[0], mem_timeout[0], stall_cycles[0]} !== 18'h0)
            $display("FAIL reset_status: got %h expected %h", {mdu_busy[0], mem_timeout[0], stall_cycles[0]}, 18'h0);
        else n_pass++;
        rst_n = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (outs(k) !== 7'b1111100) $display("FAIL first_run[%0d]: got %b expected %b", k, outs(k), 7'b1111100);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        int cnt [3];
        apply_reset();
        set_lw_hazard();
        #2;
        for (int k = 0; k < 3; k++) begin
            cnt[k] = 1;
            n_total++;
            if (outs(k) !== 7'b0011101) $display("FAIL lu_detect[%0d]: got %b expected %b", k, outs(k), 7'b0011101);
            else n_pass++;
        end
        @(negedge clk);
        ex_mem_out_ctr = 3'd0; ex_rt = 5'd0;
        for (int c = 0; c < 4; c++) begin
            #2;
            for (int k = 0; k < 3; k++) if (pc_en[k] === 1'b0) cnt[k]++;
            @(negedge clk);
        end
        #2;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (cnt[k] != k + 1 || stall_cycles[k] !== 16'(k + 1))
                $display("FAIL lu_bubbles[%0d]: got %0d stalls count %0d expected %0d", k, cnt[k], stall_cycles[k], k + 1);
            else n_pass++;
        end
        @(negedge clk);
        ex_mem_out_ctr = 3'b001; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        #2;
        n_total++;
        if ({pc_en[2], pc_en[1], pc_en[0]} !== 3'b111) $display("FAIL lu_rt_zero: got %b expected %b", {pc_en[2], pc_en[1], pc_en[0]}, 3'b111);
        else n_pass++;
        @(negedge clk);
        ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b0;
        #2;
        n_total++;
        if ({pc_en[2], pc_en[1], pc_en[0]} !== 3'b111) $display("FAIL lu_no_use: got %b expected %b", {pc_en[2], pc_en[1], pc_en[0]}, 3'b111);
        else n_pass++;
        @(negedge clk);
        ex_mem_out_ctr = 3'd0; id_uses_rs = 1'b1;
        #2;
        n_total++;
        if ({pc_en[2], pc_en[1], pc_en[0]} !== 3'b111) $display("FAIL lu_not_load: got %b expected %b", {pc_en[2], pc_en[1], pc_en[0]}, 3'b111);
        else n_pass++;
        @(negedge clk);
        ex_mem_out_ctr = 3'b100; id_rs = 5'd3; id_uses_rs = 1'b1; id_rt = 5'd5; id_uses_rt = 1'b1;
        #2;
        n_total++;
        if ({pc_en[2], pc_en[1], pc_en[0]} !== 3'b000) $display("FAIL lu_rt_match: got %b expected %b", {pc_en[2], pc_en[1], pc_en[0]}, 3'b000);
        else n_pass++;
        @(negedge clk);
        set_idle();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_mdu();
        int  stalls;
        bit  released;
        apply_reset();
        ex_mdu_start = 1'b1;
        #2;
        n_total++;
        if ({pc_en[0], mdu_busy[0]} !== 2'b10) $display("FAIL mdu_issue: got %b expected %b", {pc_en[0], mdu_busy[0]}, 2'b10);
        else n_pass++;
        @(negedge clk);
        ex_mdu_start = 1'b0; id_mdu_op = 1'b1;
        stalls = 0; released = 1'b0;
        for (int c = 0; c < 10 && !released; c++) begin
            #2;
            if (pc_en[0] === 1'b1) begin
                released = 1'b1;
                n_total++;
                if (mdu_busy[0] !== 1'b0) $display("FAIL mdu_release_busy: got %b expected %b", mdu_busy[0], 1'b0);
                else n_pass++;
            end else begin
                stalls++;
                if (c == 0) begin
                    n_total++;
                    if ({outs(0), mdu_busy[0]} !== 8'b00111011) $display("FAIL mdu_first_stall: got %b expected %b", {outs(0), mdu_busy[0]}, 8'b00111011);
                    else n_pass++;
                end
            end
            @(negedge clk);
        end
        n_total++;
        if (!released || stalls != 4) $display("FAIL mdu_stall_len: got %0d (released %0d) expected 4", stalls, released);
        else n_pass++;
        set_idle();
        @(negedge clk);
    endtask

    task automatic test_freeze();
        apply_reset();
        set_lw_hazard();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            n_total++;
            if (outs(0) !== 7'b0000000) $display("FAIL freeze_outs[%0d]: got %b expected %b", c, outs(0), 7'b0000000);
            else n_pass++;
            @(negedge clk);
        end
        dmem_ready = 1'b1;
        #2;
        n_total++;
        if (outs(0) !== 7'b0011101) $display("FAIL freeze_then_bubble: got %b expected %b", outs(0), 7'b0011101);
        else n_pass++;
        @(negedge clk);
        ex_mem_out_ctr = 3'd0; ex_rt = 5'd0;
        #2;
        n_total++;
        if ({pc_en[0], stall_cycles[0]} !== {1'b1, 16'd4}) $display("FAIL freeze_count: got %h expected %h", {pc_en[0], stall_cycles[0]}, {1'b1, 16'd4});
        else n_pass++;
        @(negedge clk);
        set_idle();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        repeat (63) @(negedge clk);
        #2;
        n_total++;
        if (mem_timeout[0] !== 1'b0) $display("FAIL timeout_early: got %b expected %b", mem_timeout[0], 1'b0);
        else n_pass++;
        @(negedge clk);
        #2;
        n_total++;
        if (mem_timeout[0] !== 1'b1) $display("FAIL timeout_set: got %b expected %b", mem_timeout[0], 1'b1);
        else n_pass++;
        @(negedge clk);
        dmem_req = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        n_total++;
        if ({mem_timeout[0], pc_en[0]} !== 2'b11) $display("FAIL timeout_sticky: got %b expected %b", {mem_timeout[0], pc_en[0]}, 2'b11);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_branch();
        apply_reset();
        set_lw_hazard();
        #2;
        n_total++;
        if (pc_en[2] !== 1'b0) $display("FAIL br_setup: got %b expected %b", pc_en[2], 1'b0);
        else n_pass++;
        @(negedge clk);
        ex_mem_out_ctr = 3'd0; ex_rt = 5'd0; ex_branch_taken = 1'b1;
        #2;
        for (int k = 1; k < 3; k++) begin
            n_total++;
            if (outs(k) !== 7'b1111111) $display("FAIL br_in_lu[%0d]: got %b expected %b", k, outs(k), 7'b1111111);
            else n_pass++;
        end
        @(negedge clk);
        set_idle();
        #2;
        n_total++;
        if (outs(2) !== 7'b1111100) $display("FAIL br_back_to_run: got %b expected %b", outs(2), 7'b1111100);
        else n_pass++;
        @(negedge clk);
        ex_branch_taken = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
        #2;
        n_total++;
        if (outs(0) !== 7'b0000000) $display("FAIL br_under_freeze: got %b expected %b", outs(0), 7'b0000000);
        else n_pass++;
        @(negedge clk);
        set_idle();
        @(negedge clk);
    endtask

    task automatic test_random();
        int lu_left [3];
        bit mwait [3];
        int sc [3];
        int mcnt, wcnt;
        bit tmo, frz, haz, stl;
        logic [6:0]  ex;
        logic [24:0] exp_v, got_v;
        apply_reset();
        mcnt = 0; wcnt = 0; tmo = 1'b0;
        for (int k = 0; k < 3; k++) begin
            lu_left[k] = 0; mwait[k] = 1'b0; sc[k] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            ex_rt = 5'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom_range(0, 1));
            id_uses_rt = 1'($urandom_range(0, 1));
            ex_mem_out_ctr = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            id_mdu_op = ($urandom_range(0, 2) == 0);
            ex_mdu_start = ($urandom_range(0, 7) == 0);
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            dmem_req = 1'($urandom_range(0, 1));
            dmem_ready = ($urandom_range(0, 3) != 0);
            #2;
            frz = dmem_req && !dmem_ready;
            haz = (ex_mem_out_ctr != 3'd0) && (ex_rt != 5'd0) &&
                  ((id_uses_rs && ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
            for (int k = 0; k < 3; k++) begin
                stl = 1'b0;
                if (frz) begin
                    ex = 7'b0000000;
                end else if (ex_branch_taken) begin
                    ex = 7'b1111111;
                    lu_left[k] = 0; mwait[k] = 1'b0;
                end else begin
                    if (lu_left[k] > 0) begin
                        stl = 1'b1; lu_left[k]--;
                    end else if (mwait[k]) begin
                        if (mcnt > 0) stl = 1'b1;
                        else mwait[k] = 1'b0;
                    end else if (haz) begin
                        stl = 1'b1; lu_left[k] = k;
                    end else if (id_mdu_op && mcnt > 0) begin
                        stl = 1'b1; mwait[k] = 1'b1;
                    end
                    ex = stl ? 7'b0011101 : 7'b1111100;
                end
                exp_v = {ex, (mcnt != 0), tmo, 16'(sc[k])};
                got_v = {outs(k), mdu_busy[k], mem_timeout[k], stall_cycles[k]};
                n_total++;
                if (got_v !== exp_v) $display("FAIL random[%0d] inst %0d: got %h expected %h", cyc, k, got_v, exp_v);
                else n_pass++;
                if (!ex[6] && sc[k] < 65535) sc[k]++;
            end
            if (ex_mdu_start && !frz) mcnt = 4;
            else if (mcnt > 0) mcnt--;
            if (frz) begin
                if (wcnt + 1 >= 64) tmo = 1'b1;
                wcnt++;
            end else begin
                wcnt = 0;
            end
            @(negedge clk);
        end
        set_idle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        ex_mdu_start = 1'b1;
        @(negedge clk);
        ex_mdu_start = 1'b0; id_mdu_op = 1'b1;
        #2;
        n_total++;
        if ({pc_en[0], mdu_busy[0]} !== 2'b01) $display("FAIL mid_setup: got %b expected %b", {pc_en[0], mdu_busy[0]}, 2'b01);
        else n_pass++;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if ({outs(k), mdu_busy[k]} !== 8'b00000110) $display("FAIL mid_reset[%0d]: got %b expected %b", k, {outs(k), mdu_busy[k]}, 8'b00000110);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        n_total++;
        if (outs(0) !== 7'b1111100) $display("FAIL mid_first_run: got %b expected %b", outs(0), 7'b1111100);
        else n_pass++;
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_saturation();
        apply_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        repeat (65534) @(negedge clk);
        #2;
        n_total++;
        if (stall_cycles[0] !== 16'hFFFE) $display("FAIL sat_below: got %h expected %h", stall_cycles[0], 16'hFFFE);
        else n_pass++;
        @(negedge clk);
        #2;
        n_total++;
        if (stall_cycles[0] !== 16'hFFFF) $display("FAIL sat_reach: got %h expected %h", stall_cycles[0], 16'hFFFF);
        else n_pass++;
        repeat (3) @(negedge clk);
        dmem_req = 1'b0;
        set_lw_hazard();
        #2;
        n_total++;
        if ({pc_en[0], stall_cycles[0]} !== {1'b0, 16'hFFFF}) $display("FAIL sat_stall: got %h expected %h", {pc_en[0], stall_cycles[0]}, {1'b0, 16'hFFFF});
        else n_pass++;
        @(negedge clk);
        set_idle();
        #2;
        n_total++;
        if (stall_cycles[0] !== 16'hFFFF) $display("FAIL sat_hold: got %h expected %h", stall_cycles[0], 16'hFFFF);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mdu();
        test_freeze();
        test_branch();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
